keypad_decimal_entry: RTL



---
 rtl/keypad_decimal_entry.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_decimal_entry.sv
// keypad_decimal_entry
// Scans a 4x4 active-low matrix keypad, debounces whole-scan results and
// assembles up to four decimal digits. The enter key converts the held
// digits to binary, one digit per cycle.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   row_n[3:0]   keypad rows, active-low, asynchronous to clk
//   col_n[3:0]   keypad column drive, exactly one bit low
//   entry_bcd    digits being entered, [15:12] oldest, unused nibbles 0
//   digit_count  number of digits held (0..4)
//   num          last converted value (0..9999)
//   num_valid    one-cycle pulse when num updates
//   busy         high while a conversion is running
module keypad_decimal_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] entry_bcd,
  output logic [2:0]  digit_count,
  output logic [13:0] num,
  output logic        num_valid,
  output logic        busy
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);
  localparam logic [STB_W-1:0] STB_FIRE = STB_W'(DEBOUNCE_SCANS - 1);

  // Key code = row*4 + col; bit 4 set means "no single key".
  localparam logic [4:0] KEY_NONE = 5'h10;
  localparam logic [3:0] KEY_BS   = 4'd7;   // B
  localparam logic [3:0] KEY_CLR  = 4'd12;  // *
  localparam logic [3:0] KEY_ENT  = 4'd14;  // #

  typedef enum logic {S_IDLE, S_CONVERT} state_t;

  function automatic logic [STB_W-1:0] sat_inc(input logic [STB_W-1:0] v);
    return (v >= STB_MAX) ? STB_MAX : v + 1'b1;
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Decimal value of a digit key, 4'hF for any non-digit key.
  function automatic logic [3:0] key_value(input logic [3:0] code);
    case (code)
      4'd0:    return 4'd1;
      4'd1:    return 4'd2;
      4'd2:    return 4'd3;
      4'd4:    return 4'd4;
      4'd5:    return 4'd5;
      4'd6:    return 4'd6;
      4'd8:    return 4'd7;
      4'd9:    return 4'd8;
      4'd10:   return 4'd9;
      4'd13:   return 4'd0;
      default: return 4'hF;
    endcase
  endfunction

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       code_q, code_d;
  logic [4:0]       key_prev_q, key_prev_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic             pressed_q, pressed_d;
  state_t           state_q, state_d;
  logic [15:0]      entry_q, entry_d;
  logic [2:0]       count_q, count_d;
  logic [1:0]       idx_q, idx_d;
  logic [13:0]      acc_q, acc_d;
  logic [13:0]      num_q, num_d;
  logic             num_valid_q, num_valid_d;

  logic             sample, scan_done;
  logic [3:0]       pressed_rows;
  logic [2:0]       col_hits, base_hits, total;
  logic [1:0]       total_sat, row_idx;
  logic [3:0]       new_code;
  logic [4:0]       key_now;
  logic             press_evt;
  logic [3:0]       evt_val, cur_digit;
  logic [13:0]      acc_next;

  // Row synchroniser and all state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      div_q       <= '0;
      col_q       <= '0;
      hits_q      <= '0;
      code_q      <= '0;
      key_prev_q  <= KEY_NONE;
      stable_q    <= '0;
      pressed_q   <= 1'b0;
      state_q     <= S_IDLE;
      entry_q     <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
    end else begin
      row_s1_q    <= row_n;
      row_s2_q    <= row_s1_q;
      div_q       <= div_d;
      col_q       <= col_d;
      hits_q      <= hits_d;
      code_q      <= code_d;
      key_prev_q  <= key_prev_d;
      stable_q    <= stable_d;
      pressed_q   <= pressed_d;
      state_q     <= state_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
    end
  end

  // Column scan: hit count and key code accumulate across the four
  // column samples; the scan result is formed on column 3's sample.
  always_comb begin
    div_d  = div_q + 1'b1;
    col_d  = col_q;
    sample = (div_q == DIV_LAST);
    if (sample) begin
      div_d = '0;
      col_d = col_q + 2'd1;
    end

    pressed_rows = ~row_s2_q;
    col_hits     = popcnt4(pressed_rows);
    row_idx      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pressed_rows[i]) row_idx = 2'(i);
    end

    base_hits = (col_q == 2'd0) ? 3'd0 : {1'b0, hits_q};
    total     = base_hits + col_hits;
    total_sat = (total >= 3'd2) ? 2'd2 : total[1:0];
    new_code  = (col_hits == 3'd1) ? {row_idx, col_q} : code_q;

    hits_d = hits_q;
    code_d = code_q;
    if (sample) begin
      hits_d = total_sat;
      code_d = new_code;
    end

    scan_done = sample && (col_q == 2'd3);
    key_now   = (total_sat == 2'd1) ? {1'b0, new_code} : KEY_NONE;
  end

  // Debounce, evaluated once per completed scan
  always_comb begin
    key_prev_d = key_prev_q;
    stable_d   = stable_q;
    pressed_d  = pressed_q;
    press_evt  = 1'b0;
    if (scan_done) begin
      stable_d   = (key_now == key_prev_q) ? sat_inc(stable_q) : '0;
      key_prev_d = key_now;
      if (key_now != KEY_NONE) begin
        if (!pressed_q && (stable_d == STB_FIRE)) begin
          press_evt = 1'b1;
          pressed_d = 1'b1;
        end
      end else if (stable_d >= STB_FIRE) begin
        pressed_d = 1'b0;
      end
    end
  end

  // Entry and conversion FSM
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    count_d     = count_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    num_d       = num_q;
    num_valid_d = 1'b0;

    evt_val = key_value(key_now[3:0]);

    case (idx_q)
      2'd0:    cur_digit = entry_q[15:12];
      2'd1:    cur_digit = entry_q[11:8];
      2'd2:    cur_digit = entry_q[7:4];
      default: cur_digit = entry_q[3:0];
    endcase
    acc_next = (acc_q << 3) + (acc_q << 1) + {10'd0, cur_digit};

    case (state_q)
      S_IDLE: begin
        if (press_evt) begin
          if (evt_val != 4'hF) begin
            case (count_q)
              3'd0:    begin entry_d[15:12] = evt_val; count_d = 3'd1; end
              3'd1:    begin entry_d[11:8]  = evt_val; count_d = 3'd2; end
              3'd2:    begin entry_d[7:4]   = evt_val; count_d = 3'd3; end
              3'd3:    begin entry_d[3:0]   = evt_val; count_d = 3'd4; end
              default: ;
            endcase
          end else if (key_now[3:0] == KEY_BS) begin
            case (count_q)
              3'd1:    begin entry_d[15:12] = 4'd0; count_d = 3'd0; end
              3'd2:    begin entry_d[11:8]  = 4'd0; count_d = 3'd1; end
              3'd3:    begin entry_d[7:4]   = 4'd0; count_d = 3'd2; end
              3'd4:    begin entry_d[3:0]   = 4'd0; count_d = 3'd3; end
              default: ;
            endcase
          end else if (key_now[3:0] == KEY_CLR) begin
            entry_d = '0;
            count_d = '0;
          end else if (key_now[3:0] == KEY_ENT) begin
            if (count_q != 3'd0) begin
              state_d = S_CONVERT;
              idx_d   = '0;
              acc_d   = '0;
            end
          end
        end
      end
      S_CONVERT: begin
        // The last digit's result goes straight to num so num_valid
        // appears the cycle after the final accumulate cycle.
        acc_d = acc_next;
        idx_d = idx_q + 2'd1;
        if ((3'(idx_q) + 3'd1) == count_q) begin
          num_d       = acc_next;
          num_valid_d = 1'b1;
          entry_d     = '0;
          count_d     = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign col_n       = ~(4'b0001 << col_q);
  assign entry_bcd   = entry_q;
  assign digit_count = count_q;
  assign num         = num_q;
  assign num_valid   = num_valid_q;
  assign busy        = (state_q == S_CONVERT);

endmodule
